// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch-to-decode bus layout shared by IF, ID and the instruction queue.
package cpu_pkg;
  localparam int FS_TO_DS_BUS_W = 66;
  localparam int PC_LSB = 0;
  localparam int INST_LSB = 32;
  localparam int ADEF_BIT = 64;
  localparam int REFETCH_BIT = 65;
  typedef struct packed {
    logic        refetch_needed;
    logic        adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_bus_t;
endpackage

// File: rtl/if_id_inst_queue_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO with registered storage and a
// synchronous flush that empties it in one edge.
module sync_fifo_fwft #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, ptr_diff;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic wr, rd;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign count = count_q;
  assign rd_data = empty ? '0 : mem_q[rptr_q];
  assign wr = wr_en & ~full & ~flush;
  assign rd = rd_en & ~empty & ~flush;
  assign ptr_diff = wptr_q - rptr_q;
  always_comb begin
    wptr_d = flush ? '0 : wptr_q + AW'(wr);
    rptr_d = flush ? '0 : rptr_q + AW'(rd);
    count_d = flush ? '0 : count_q + CW'(wr) - CW'(rd);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk)
    if (wr) mem_q[wptr_q] <= wr_data;
  always_ff @(posedge clk)
    if (!rst) assert (count_q <= CW'(DEPTH) && (full ? ptr_diff == '0 : count_q == {1'b0, ptr_diff}));
endmodule

// File: rtl/if_id_inst_queue.sv
// if_id_inst_queue: decoupling queue between IF and ID; ds_allowin depends only
// on registered occupancy so there is no id_allowin -> ds_allowin path.
module if_id_inst_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int BUS_W = FS_TO_DS_BUS_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fs_to_ds_valid,
  input  logic [BUS_W-1:0] fs_to_ds_bus,
  output logic             ds_allowin,
  output logic             q_to_ds_valid,
  output logic [BUS_W-1:0] q_to_ds_bus,
  input  logic             id_allowin,
  input  logic             flush,
  output logic [CNT_W-1:0] q_count
);
  logic full, empty, enq, deq;
  assign ds_allowin = ~full;
  assign q_to_ds_valid = ~empty;
  assign enq = fs_to_ds_valid & ds_allowin & ~flush;
  assign deq = q_to_ds_valid & id_allowin & ~flush;
  sync_fifo_fwft #(.DEPTH(DEPTH), .WIDTH(BUS_W)) u_fifo (
    .clk(clk),
    .rst(reset),
    .flush(flush),
    .wr_en(enq),
    .wr_data(fs_to_ds_bus),
    .rd_en(deq),
    .rd_data(q_to_ds_bus),
    .empty(empty),
    .full(full),
    .count(q_count)
  );
endmodule

// File: tb/tb_if_id_inst_queue.sv
// tb_if_id_inst_queue: randomized and directed stimulus against an ordered-queue
// reference; a negedge monitor pops expected entries as ID accepts them.
module tb_if_id_inst_queue;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1;
  logic fs_to_ds_valid = 0, id_allowin = 0, flush = 0;
  logic [65:0] fs_to_ds_bus = '0;
  logic ds_allowin, q_to_ds_valid;
  logic [65:0] q_to_ds_bus;
  logic [2:0] q_count;
  int checks = 0, errors = 0;
  int m_cnt = 0, m_nxt = 0;
  logic [65:0] exp_q[$];

  if_id_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allowin(ds_allowin), .q_to_ds_valid(q_to_ds_valid), .q_to_ds_bus(q_to_ds_bus),
    .id_allowin(id_allowin), .flush(flush), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [65:0] a, logic [65:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  function automatic logic [65:0] mk(logic [31:0] pc);
    logic [31:0] inst = $urandom();
    return {2'b00, inst, pc};
  endfunction

  task automatic cycle(input logic v, input logic [65:0] b, input logic a, input logic f);
    bit enq, deq;
    @(posedge clk); #1;
    m_cnt = m_nxt;
    fs_to_ds_valid = v; fs_to_ds_bus = b; id_allowin = a; flush = f;
    if (f) begin
      exp_q.delete();
      m_nxt = 0;
    end else begin
      enq = v && m_cnt != DEPTH;
      deq = a && m_cnt != 0;
      if (enq) exp_q.push_back(b);
      m_nxt = m_cnt + int'(enq) - int'(deq);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    assert (!$isunknown(fs_to_ds_valid));
    chk("q_count", 66'(q_count), 66'(m_cnt));
    chk("ds_allowin", 66'(ds_allowin), 66'(m_cnt != DEPTH));
    chk("q_to_ds_valid", 66'(q_to_ds_valid), 66'(m_cnt != 0));
    if (!q_to_ds_valid) chk("idle_bus", q_to_ds_bus, '0);
    else if (id_allowin && !flush) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop: unexpected entry %h, expected none", q_to_ds_bus);
      end else chk("head_bus", q_to_ds_bus, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_valid", 66'(q_to_ds_valid), 66'(0));
    chk("rst_count", 66'(q_count), 66'(0));
    chk("rst_allowin", 66'(ds_allowin), 66'(1));
    chk("rst_bus", q_to_ds_bus, '0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    // fill with ID stalled, offer a fifth, then drain in order
    for (int i = 0; i < 5; i++) cycle(1, mk(32'h1C000000 + 32'(4 * i)), 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, '0, 1, 0);
    // continuous stream, many pointer wraps
    for (int i = 0; i < 40; i++) cycle(1, mk(32'h1C001000 + 32'(4 * i)), 1, 0);
    for (int i = 0; i < 2; i++) cycle(0, '0, 1, 0);
    // full queue with simultaneous offer and accept
    for (int i = 0; i < 4; i++) cycle(1, mk(32'h1C002000 + 32'(4 * i)), 0, 0);
    cycle(1, mk(32'h1C002010), 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0);
    // flush with a concurrent offer, then the redirected entry
    for (int i = 0; i < 3; i++) cycle(1, mk(32'h1C000010 + 32'(4 * i)), 0, 0);
    cycle(1, mk(32'h1C000020), 0, 1);
    cycle(1, mk(32'h1C008000), 0, 1);
    cycle(1, mk(32'h1C008000), 1, 0);
    for (int i = 0; i < 2; i++) cycle(0, '0, 1, 0);
    // adef and refetch bits pass through unchanged
    cycle(1, {2'b11, 32'hDEADBEEF, 32'h1C000002}, 0, 0);
    cycle(1, {2'b10, 32'h00000000, 32'hFFFFFFFF}, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
    // asynchronous reset between edges with two entries held
    cycle(1, mk(32'h1C000100), 0, 0);
    cycle(1, mk(32'h1C000104), 0, 0);
    cycle(0, '0, 0, 0);
    #3 reset = 1;
    #1;
    chk("async_valid", 66'(q_to_ds_valid), 66'(0));
    chk("async_count", 66'(q_count), 66'(0));
    chk("async_allowin", 66'(ds_allowin), 66'(1));
    exp_q.delete(); m_cnt = 0; m_nxt = 0;
    #2 reset = 0;
    cycle(1, mk(32'h1C000200), 0, 0);
    for (int i = 0; i < 2; i++) cycle(0, '0, 1, 0);
    // random traffic
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(99) < 70, mk($urandom()), $urandom_range(99) < 60, $urandom_range(99) < 5);
    for (int i = 0; i < 6; i++) cycle(0, '0, 1, 0);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
